disp_source_arbiter: RTL and testbench

//  Parametrised display arbiter for the range-hood top level. It selects one of NUM_SRC

---
 rtl/disp_source_arbiter.sv | 168 ++++++++++++++++
 tb/tb_disp_source_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_source_arbiter.sv
// Display source arbiter: picks one of NUM_SRC 7-seg bundles from a mode->source map,
// with timed, cancellable overlays and blanking while the machine is off.
module disp_source_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = 2,
  parameter int MODE_W = 3,
  parameter logic [(2**MODE_W)*SRC_W-1:0] MODE_MAP = 16'h5A40,
  parameter int OVL_TICKS = 5,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 machine_state,
  input  logic [MODE_W-1:0]    mode_state,
  input  logic                 tick,
  input  logic [NUM_SRC-1:0]   ovl_req,
  input  logic                 ovl_cancel,
  input  logic [NUM_SRC*8-1:0] src_digit1,
  input  logic [NUM_SRC*8-1:0] src_digit2,
  input  logic [NUM_SRC*8-1:0] src_tube_sel,
  output logic [7:0]           digit1,
  output logic [7:0]           digit2,
  output logic [7:0]           tube_sel,
  output logic [SRC_W-1:0]     active_src,
  output logic                 ovl_active
);

  localparam bit OVL_EN = (OVL_TICKS != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OVL_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {ST_OFF, ST_BASE, ST_OVERLAY} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SRC_W-1:0]  ovl_src_reg, ovl_src_next;

  logic [SRC_W-1:0]  mode_map_arr [2**MODE_W];
  logic [SRC_W-1:0]  req_idx;
  logic              req_any;

  logic [SRC_W-1:0]  sel_src;
  logic              show;
  logic [7:0]        digit1_next, digit2_next, tube_sel_next;
  logic [SRC_W-1:0]  active_src_next;
  logic              ovl_active_next;

  for (genvar gi = 0; gi < 2**MODE_W; gi++) begin : g_map
    assign mode_map_arr[gi] = MODE_MAP[gi*SRC_W +: SRC_W];
  end

  assign req_any = |ovl_req;

  // Lowest set request bit wins.
  always_comb begin
    req_idx = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (ovl_req[s]) req_idx = SRC_W'(s);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_OFF;
      cnt_reg     <= '0;
      ovl_src_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ovl_src_reg <= ovl_src_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ovl_src_next = ovl_src_reg;
    case (state_reg)
      ST_OFF: begin
        if (machine_state) state_next = ST_BASE;
      end
      ST_BASE: begin
        if (!machine_state) begin
          state_next = ST_OFF;
        end else if (OVL_EN && req_any) begin
          state_next   = ST_OVERLAY;
          ovl_src_next = req_idx;
          cnt_next     = CNT_LOAD;
        end
      end
      ST_OVERLAY: begin
        if (!machine_state) begin
          state_next   = ST_OFF;
          cnt_next     = '0;
          ovl_src_next = '0;
        end else if (ovl_cancel) begin
          state_next = ST_BASE;
          cnt_next   = '0;
        end else if (req_any) begin
          ovl_src_next = req_idx;
          cnt_next     = CNT_LOAD;
        end else if (tick) begin
          if (cnt_reg == CNT_ONE) begin
            state_next = ST_BASE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
      end
      default: begin
        state_next   = ST_OFF;
        cnt_next     = '0;
        ovl_src_next = '0;
      end
    endcase
  end

  // Selection follows the next state so outputs move on the same edge as the state.
  always_comb begin
    sel_src         = '0;
    show            = 1'b0;
    digit1_next     = '0;
    digit2_next     = '0;
    tube_sel_next   = '0;
    case (state_next)
      ST_BASE: begin
        sel_src = mode_map_arr[mode_state];
        show    = 1'b1;
      end
      ST_OVERLAY: begin
        sel_src = ovl_src_next;
        show    = 1'b1;
      end
      default: begin
        sel_src = '0;
        show    = 1'b0;
      end
    endcase
    // Out-of-range map entries match no source and therefore stay blank.
    for (int s = 0; s < NUM_SRC; s++) begin
      if (show && sel_src == SRC_W'(s)) begin
        digit1_next   = src_digit1[s*8 +: 8];
        digit2_next   = src_digit2[s*8 +: 8];
        tube_sel_next = src_tube_sel[s*8 +: 8];
      end
    end
    active_src_next = show ? sel_src : '0;
    ovl_active_next = (state_next == ST_OVERLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit1     <= '0;
      digit2     <= '0;
      tube_sel   <= '0;
      active_src <= '0;
      ovl_active <= 1'b0;
    end else begin
      digit1     <= digit1_next;
      digit2     <= digit2_next;
      tube_sel   <= tube_sel_next;
      active_src <= active_src_next;
      ovl_active <= ovl_active_next;
    end
  end

endmodule

// File: tb/tb_disp_source_arbiter.sv
// Bench for disp_source_arbiter: directed vector table, async-reset and blank-entry
// sequences, then randomized traffic against a behavioural model.
module tb_disp_source_arbiter;

  localparam logic [15:0] MAP_A = 16'h5A40;
  localparam logic [23:0] MAP_B = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam int TICKS_A = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: default parameters
  logic        ms, tick, cancel;
  logic [2:0]  mode;
  logic [3:0]  req;
  logic [31:0] sd1, sd2, sts;
  logic [7:0]  d1, d2, ts;
  logic [1:0]  asrc;
  logic        ovl;

  // DUT B: six sources, map entries 6 and 7 point at nothing
  logic        ms_b, tick_b, cancel_b;
  logic [2:0]  mode_b;
  logic [5:0]  req_b;
  logic [47:0] sd1_b, sd2_b, sts_b;
  logic [7:0]  d1_b, d2_b, ts_b;
  logic [2:0]  asrc_b;
  logic        ovl_b;

  disp_source_arbiter dut_a (
    .clk(clk), .rst(rst), .machine_state(ms), .mode_state(mode), .tick(tick),
    .ovl_req(req), .ovl_cancel(cancel), .src_digit1(sd1), .src_digit2(sd2),
    .src_tube_sel(sts), .digit1(d1), .digit2(d2), .tube_sel(ts),
    .active_src(asrc), .ovl_active(ovl)
  );

  disp_source_arbiter #(
    .NUM_SRC(6), .SRC_W(3), .MODE_W(3), .MODE_MAP(MAP_B), .OVL_TICKS(3), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .machine_state(ms_b), .mode_state(mode_b), .tick(tick_b),
    .ovl_req(req_b), .ovl_cancel(cancel_b), .src_digit1(sd1_b), .src_digit2(sd2_b),
    .src_tube_sel(sts_b), .digit1(d1_b), .digit2(d2_b), .tube_sel(ts_b),
    .active_src(asrc_b), .ovl_active(ovl_b)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       ms;
    logic [2:0] mode;
    logic       tick;
    logic [3:0] req;
    logic       cancel;
    logic       exp_on;
    logic [1:0] exp_src;
    logic       exp_ovl;
  } vec_t;
  vec_t vt[28];

  // Behavioural model state for DUT A
  bit       m_on, m_in_ovl;
  int       m_src, m_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] act_a();
    return {5'd0, ovl, asrc, ts, d2, d1};
  endfunction

  function automatic logic [31:0] exp_a(input logic on, input int src, input logic o);
    if (!on) return '0;
    return {5'd0, o, 2'(src), sts[src*8 +: 8], sd2[src*8 +: 8], sd1[src*8 +: 8]};
  endfunction

  function automatic int lowest_bit(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int map_a(input logic [2:0] m);
    return int'((MAP_A >> (int'(m) * 2)) & 16'h3);
  endfunction

  // One clock of the model, applied with the inputs present at the edge.
  task automatic model_step();
    if (!ms) begin
      m_on = 0; m_in_ovl = 0;
    end else if (!m_on) begin
      m_on = 1;
    end else if (!m_in_ovl) begin
      if (req != 0) begin
        m_in_ovl = 1; m_src = lowest_bit(req); m_left = TICKS_A;
      end
    end else if (cancel) begin
      m_in_ovl = 0;
    end else if (req != 0) begin
      m_src = lowest_bit(req); m_left = TICKS_A;
    end else if (tick) begin
      m_left--;
      if (m_left == 0) m_in_ovl = 0;
    end
  endtask

  function automatic logic [31:0] model_exp();
    if (!m_on) return '0;
    return exp_a(1'b1, m_in_ovl ? m_src : map_a(mode), m_in_ovl);
  endfunction

  function automatic logic [31:0] exp_b(input int src, input logic o);
    if (src >= 6) return {4'd0, o, 3'(src), 24'd0};
    return {4'd0, o, 3'(src), sts_b[src*8 +: 8], sd2_b[src*8 +: 8], sd1_b[src*8 +: 8]};
  endfunction

  initial begin
    rst = 1'b0;
    ms = 0; mode = 3'd3; tick = 0; req = '0; cancel = 0;
    sd1 = {8'hD3, 8'hC2, 8'h3F, 8'hA0};
    sd2 = {8'hB3, 8'hB2, 8'h06, 8'hB0};
    sts = {8'h08, 8'h04, 8'h01, 8'h0E};
    ms_b = 0; mode_b = '0; tick_b = 0; req_b = '0; cancel_b = 0;
    for (int s = 0; s < 6; s++) begin
      sd1_b[s*8 +: 8] = 8'h40 + 8'(s);
      sd2_b[s*8 +: 8] = 8'h50 + 8'(s);
      sts_b[s*8 +: 8] = 8'h01 << s;
    end

    //               ms mode tick req  cancel on src ovl
    vt[0]  = '{1'b0, 3'd3, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[1]  = '{1'b1, 3'd3, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0};
    vt[2]  = '{1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[3]  = '{1'b1, 3'd0, 1'b0, 4'h6, 1'b0, 1'b1, 2'd1, 1'b1};
    vt[4]  = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1};
    vt[5]  = '{1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1};
    vt[6]  = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1};
    vt[7]  = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1};
    vt[8]  = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1};
    vt[9]  = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[10] = '{1'b1, 3'd0, 1'b0, 4'h4, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[11] = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[12] = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[13] = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[14] = '{1'b1, 3'd0, 1'b1, 4'h8, 1'b0, 1'b1, 2'd3, 1'b1};
    vt[15] = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 1'b1};
    vt[16] = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 1'b1};
    vt[17] = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 1'b1};
    vt[18] = '{1'b1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 1'b1};
    vt[19] = '{1'b1, 3'd0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[20] = '{1'b1, 3'd0, 1'b0, 4'h1, 1'b0, 1'b1, 2'd0, 1'b1};
    vt[21] = '{1'b1, 3'd4, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 1'b1};
    vt[22] = '{1'b0, 3'd4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[23] = '{1'b1, 3'd4, 1'b0, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0};
    vt[24] = '{1'b0, 3'd4, 1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[25] = '{1'b1, 3'd7, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0};
    vt[26] = '{1'b1, 3'd7, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0};
    vt[27] = '{1'b1, 3'd7, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0};

    // Reset state while rst is held low
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", act_a(), 32'd0);
    check("reset_b", {4'd0, ovl_b, asrc_b, ts_b, d2_b, d1_b}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      ms = vt[i].ms; mode = vt[i].mode; tick = vt[i].tick;
      req = vt[i].req; cancel = vt[i].cancel;
      @(posedge clk);
      #1;
      $display("vec %0d: ms=%0d mode=%0d tick=%0d req=%h cancel=%0d -> src=%0d ovl=%0d d1=%h d2=%h ts=%h",
               i, ms, mode, tick, req, cancel, asrc, ovl, d1, d2, ts);
      check($sformatf("vec%0d", i), act_a(), exp_a(vt[i].exp_on, int'(vt[i].exp_src), vt[i].exp_ovl));
    end

    // Async reset mid-overlay clears outputs without a clock edge
    ms = 1; mode = 3'd0; tick = 0; cancel = 0; req = 4'h4;
    @(posedge clk);
    #1;
    req = '0;
    check("ovl_before_rst", act_a(), exp_a(1'b1, 2, 1'b1));
    #2;
    rst = 1'b0;
    #1;
    $display("async reset: src=%0d ovl=%0d d1=%h", asrc, ovl, d1);
    check("async_rst", act_a(), 32'd0);
    ms = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("off_after_rst", act_a(), 32'd0);

    // Randomized traffic against the model
    m_on = 0; m_in_ovl = 0; m_src = 0; m_left = 0;
    for (int i = 0; i < 400; i++) begin
      ms     = ($urandom_range(0, 19) != 0);
      mode   = 3'($urandom_range(0, 7));
      tick   = ($urandom_range(0, 2) == 0);
      req    = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cancel = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        sd1 = $urandom; sd2 = $urandom; sts = $urandom;
      end
      @(posedge clk);
      model_step();
      #1;
      $display("rnd %0d: ms=%0d mode=%0d tick=%0d req=%h cancel=%0d -> src=%0d ovl=%0d",
               i, ms, mode, tick, req, cancel, asrc, ovl);
      check($sformatf("rnd%0d", i), act_a(), model_exp());
    end
    ms = 0; req = '0; tick = 0; cancel = 0;

    // DUT B: unmapped entries blank but still report the raw entry
    ms_b = 1;
    for (int m = 0; m < 8; m++) begin
      mode_b = 3'(m);
      @(posedge clk);
      #1;
      $display("B mode %0d -> src=%0d d1=%h d2=%h ts=%h", m, asrc_b, d1_b, d2_b, ts_b);
      check($sformatf("b_mode%0d", m), {4'd0, ovl_b, asrc_b, ts_b, d2_b, d1_b}, exp_b(m, 1'b0));
    end
    req_b = 6'b110000;
    @(posedge clk);
    #1;
    req_b = '0;
    $display("B overlay -> src=%0d ovl=%0d d1=%h", asrc_b, ovl_b, d1_b);
    check("b_ovl", {4'd0, ovl_b, asrc_b, ts_b, d2_b, d1_b}, exp_b(4, 1'b1));
    ms_b = 0;
    @(posedge clk);
    #1;
    check("b_off", {4'd0, ovl_b, asrc_b, ts_b, d2_b, d1_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
